// File: rtl/wdt_kick_ctrl.sv
// Watchdog kick controller.
// Programs the watchdog over its register bus (unlock, LOAD, WINDOW, CTRL, lock) and then
// refreshes it only once every heartbeat source has checked in since the previous kick, and
// never while the watchdog COUNT is still above the window in window mode.
// Optional feature: define WDT_KICK_CTRL_EWI_CLEAR_EN to follow every kick with a W1C write
// of the EWIF bit in STATUS.
module wdt_kick_ctrl #(
  parameter int unsigned NUM_HB        = 4,
  parameter int unsigned POLL_INTERVAL = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_start_i,
  input  logic [31:0]       cfg_load_i,
  input  logic [31:0]       cfg_window_i,
  input  logic [31:0]       cfg_ctrl_i,
  input  logic [NUM_HB-1:0] hb_i,
  output logic              wdt_stb_o,
  output logic              wdt_we_o,
  output logic [3:0]        wdt_adr_o,
  output logic [3:0]        wdt_byte_sel_o,
  output logic [31:0]       wdt_dat_o,
  input  logic [31:0]       wdt_dat_i,
  output logic              busy_o,
  output logic              running_o,
  output logic              kick_o,
  output logic              late_o,
  output logic [NUM_HB-1:0] hb_seen_o
);

  localparam int unsigned TimerW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL + 1) : 1;

  // Watchdog register map (word addresses) and key values.
  localparam logic [3:0]  AdrCtrl    = 4'd0;
  localparam logic [3:0]  AdrLoad    = 4'd1;
  localparam logic [3:0]  AdrCount   = 4'd2;
  localparam logic [3:0]  AdrWindow  = 4'd3;
  localparam logic [3:0]  AdrKey     = 4'd4;
`ifdef WDT_KICK_CTRL_EWI_CLEAR_EN
  localparam logic [3:0]  AdrStatus  = 4'd5;
  localparam logic [31:0] EwifClear  = 32'h0000_0001;
`endif
  localparam logic [31:0] KeyUnlock  = 32'h1234_5678;
  localparam logic [31:0] KeyLock    = 32'hDEAD_BEEF;
  localparam logic [31:0] KeyRefresh = 32'h5A5A_5A5A;

  typedef enum logic [3:0] {
    StIdle,
    StUnlock,
    StWrLoad,
    StWrWin,
    StWrCtrl,
    StLock,
    StRun,
    StPoll,
    StWait,
    StKick
`ifdef WDT_KICK_CTRL_EWI_CLEAR_EN
    , StClr
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         load_q, window_q, ctrl_q;
  logic [NUM_HB-1:0]   hb_seen_q, hb_seen_d;
  logic                late_q, late_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                running;

  assign running = (state_q == StRun) || (state_q == StPoll) || (state_q == StWait) ||
`ifdef WDT_KICK_CTRL_EWI_CLEAR_EN
                   (state_q == StClr) ||
`endif
                   (state_q == StKick);

  // State, heartbeat mask, late flag, poll timer and latched configuration.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      load_q    <= '0;
      window_q  <= '0;
      ctrl_q    <= '0;
      hb_seen_q <= '0;
      late_q    <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      hb_seen_q <= hb_seen_d;
      late_q    <= late_d;
      timer_q   <= timer_d;
      if (cfg_start_i) begin
        load_q   <= cfg_load_i;
        window_q <= cfg_window_i;
        ctrl_q   <= cfg_ctrl_i;
      end
    end
  end

  // Next-state logic: config sequence, heartbeat gating, window polling.
  always_comb begin
    state_d   = state_q;
    hb_seen_d = hb_seen_q;
    late_d    = late_q;
    timer_d   = timer_q;

    if (running) begin
      hb_seen_d = hb_seen_q | hb_i;
    end

    unique case (state_q)
      StIdle:   state_d = StIdle;
      StUnlock: state_d = StWrLoad;
      StWrLoad: state_d = StWrWin;
      StWrWin:  state_d = StWrCtrl;
      StWrCtrl: state_d = StLock;
      StLock:   state_d = StRun;
      StRun: begin
        // A disabled watchdog (ctrl[0]=0) is never polled or refreshed.
        if (ctrl_q[0] && (&hb_seen_q)) begin
          state_d = StPoll;
        end
      end
      StPoll: begin
        if (wdt_dat_i == 32'd0) begin
          late_d  = 1'b1;
          state_d = StKick;
        end else if (ctrl_q[2] && (wdt_dat_i > window_q)) begin
          // Still in the early region: refreshing now would trip the watchdog.
          state_d = StWait;
          timer_d = TimerW'(POLL_INTERVAL);
        end else begin
          state_d = StKick;
        end
      end
      StWait: begin
        timer_d = timer_q - TimerW'(1);
        if (timer_q <= TimerW'(1)) begin
          state_d = StPoll;
        end
      end
      StKick: begin
        // A heartbeat coincident with the kick belongs to the next epoch.
        hb_seen_d = hb_i;
`ifdef WDT_KICK_CTRL_EWI_CLEAR_EN
        state_d   = StClr;
`else
        state_d   = StRun;
`endif
      end
`ifdef WDT_KICK_CTRL_EWI_CLEAR_EN
      StClr:    state_d = StRun;
`endif
      default:  state_d = StIdle;
    endcase

    if (cfg_start_i) begin
      state_d   = StUnlock;
      hb_seen_d = '0;
      late_d    = 1'b0;
    end
  end

  // Bus access performed in each state; one single-cycle access per state.
  always_comb begin
    wdt_stb_o = 1'b0;
    wdt_we_o  = 1'b0;
    wdt_adr_o = '0;
    wdt_dat_o = '0;
    unique case (state_q)
      StUnlock: begin
        wdt_stb_o = 1'b1;
        wdt_we_o  = 1'b1;
        wdt_adr_o = AdrKey;
        wdt_dat_o = KeyUnlock;
      end
      StWrLoad: begin
        wdt_stb_o = 1'b1;
        wdt_we_o  = 1'b1;
        wdt_adr_o = AdrLoad;
        wdt_dat_o = load_q;
      end
      StWrWin: begin
        wdt_stb_o = 1'b1;
        wdt_we_o  = 1'b1;
        wdt_adr_o = AdrWindow;
        wdt_dat_o = window_q;
      end
      StWrCtrl: begin
        wdt_stb_o = 1'b1;
        wdt_we_o  = 1'b1;
        wdt_adr_o = AdrCtrl;
        wdt_dat_o = ctrl_q;
      end
      StLock: begin
        wdt_stb_o = 1'b1;
        wdt_we_o  = 1'b1;
        wdt_adr_o = AdrKey;
        wdt_dat_o = KeyLock;
      end
      StPoll: begin
        wdt_stb_o = 1'b1;
        wdt_adr_o = AdrCount;
      end
      StKick: begin
        wdt_stb_o = 1'b1;
        wdt_we_o  = 1'b1;
        wdt_adr_o = AdrKey;
        wdt_dat_o = KeyRefresh;
      end
`ifdef WDT_KICK_CTRL_EWI_CLEAR_EN
      StClr: begin
        wdt_stb_o = 1'b1;
        wdt_we_o  = 1'b1;
        wdt_adr_o = AdrStatus;
        wdt_dat_o = EwifClear;
      end
`endif
      default: ;
    endcase
  end

  assign wdt_byte_sel_o = 4'hF;
  assign busy_o         = (state_q == StUnlock) || (state_q == StWrLoad) ||
                          (state_q == StWrWin)  || (state_q == StWrCtrl) || (state_q == StLock);
  assign running_o      = running;
  assign kick_o         = (state_q == StKick);
  assign late_o         = late_q;
  assign hb_seen_o      = hb_seen_q;

endmodule

// File: tb/tb_wdt_kick_ctrl.sv
// Bench for wdt_kick_ctrl: a small watchdog model answers COUNT reads, an event-level reference
// model predicts every bus access with its cycle, and a monitor pops and compares them.
module tb_wdt_kick_ctrl;

  localparam int unsigned NHB = 4;
  localparam int unsigned PI  = 7;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            cfg_start_i = 1'b0;
  logic [31:0]     cfg_load_i = '0, cfg_window_i = '0, cfg_ctrl_i = '0;
  logic [NHB-1:0]  hb_i = '0;
  logic            wdt_stb_o, wdt_we_o;
  logic [3:0]      wdt_adr_o, wdt_byte_sel_o;
  logic [31:0]     wdt_dat_o, wdt_dat_i;
  logic            busy_o, running_o, kick_o, late_o;
  logic [NHB-1:0]  hb_seen_o;

  always #5 clk = ~clk;

  wdt_kick_ctrl #(.NUM_HB(NHB), .POLL_INTERVAL(PI)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_start_i(cfg_start_i), .cfg_load_i(cfg_load_i),
    .cfg_window_i(cfg_window_i), .cfg_ctrl_i(cfg_ctrl_i), .hb_i(hb_i),
    .wdt_stb_o(wdt_stb_o), .wdt_we_o(wdt_we_o), .wdt_adr_o(wdt_adr_o),
    .wdt_byte_sel_o(wdt_byte_sel_o), .wdt_dat_o(wdt_dat_o), .wdt_dat_i(wdt_dat_i),
    .busy_o(busy_o), .running_o(running_o), .kick_o(kick_o), .late_o(late_o),
    .hb_seen_o(hb_seen_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Watchdog model: counts down, reloads on refresh key, pulses a reset when it expires.
  logic [31:0] wd_cnt = '0, wd_load = '0, ovr_val = '0;
  logic        ovr_en = 1'b0;
  int          wd_rst_cnt = 0;
  assign wdt_dat_i = ovr_en ? ovr_val : wd_cnt;

  always @(posedge clk) begin
    if (wdt_stb_o && wdt_we_o && wdt_adr_o == 4'd1) begin
      wd_load <= wdt_dat_o;
      wd_cnt  <= wdt_dat_o;
    end else if (wdt_stb_o && wdt_we_o && wdt_adr_o == 4'd4 && wdt_dat_o == 32'h5A5A_5A5A) begin
      wd_cnt <= wd_load;
    end else if (wd_cnt != 32'd0) begin
      wd_cnt <= wd_cnt - 32'd1;
    end else if (wd_load != 32'd0) begin
      wd_rst_cnt <= wd_rst_cnt + 1;
      wd_cnt     <= wd_load;
    end
  end

  // Scoreboard of expected bus accesses.
  typedef struct {
    int          cy;
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat;
    logic        kick;
  } acc_t;
  acc_t exp_q[$];
  acc_t mon_e;
  int   kick_obs = 0;

  function automatic void push(input int cy, input logic we, input logic [3:0] adr,
                               input logic [31:0] dat, input logic kick);
    acc_t e;
    e.cy = cy; e.we = we; e.adr = adr; e.dat = dat; e.kick = kick;
    exp_q.push_back(e);
  endfunction

  // Monitor: sample mid-cycle, compare every access against the queue head.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cy < cyc) begin
      mon_e = exp_q.pop_front();
      chk("missing_access_cycle", 32'(cyc), 32'(mon_e.cy));
    end
    if (wdt_stb_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_access_stb", 32'(wdt_stb_o), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("access_cycle", 32'(cyc), 32'(mon_e.cy));
        chk("access_we", 32'(wdt_we_o), 32'(mon_e.we));
        chk("access_adr", 32'(wdt_adr_o), 32'(mon_e.adr));
        if (mon_e.we) chk("access_dat", wdt_dat_o, mon_e.dat);
        chk("byte_sel", 32'(wdt_byte_sel_o), 32'hF);
        chk("kick_pulse", 32'(kick_o), 32'(mon_e.kick));
      end
    end else begin
      chk("idle_bus", {27'd0, wdt_we_o, wdt_adr_o}, 32'd0);
      chk("idle_dat", wdt_dat_o, 32'd0);
      chk("idle_kick", 32'(kick_o), 32'd0);
    end
    if (kick_o === 1'b1) kick_obs++;
  end

  // Reference model: epoch events expressed as cycle numbers.
  int             run_from = -1, poll_at = -1, kick_at = -1, m_kicks = 0;
  logic [NHB-1:0] m_seen = '0;
  logic           m_late = 1'b0;
  logic [31:0]    m_win = '0, m_ctrl = '0;

  task automatic step(input logic [NHB-1:0] hb, input bit start, input bit rst);
    int          c;
    bit          running, polling, kicking, idle_run, full;
    logic [31:0] v;
    c        = cyc;
    running  = (run_from >= 0) && (c >= run_from);
    chk("running_o", 32'(running_o), 32'(running));
    chk("busy_o", 32'(busy_o), 32'((run_from >= 0) && (c >= run_from - 5) && (c < run_from)));
    chk("hb_seen_o", 32'(hb_seen_o), 32'(m_seen));
    chk("late_o", 32'(late_o), 32'(m_late));
    hb_i        = hb;
    cfg_start_i = start;
    rst_ni      = !rst;
    polling  = (c == poll_at);
    kicking  = (c == kick_at);
    idle_run = running && !polling && !kicking && (poll_at < c) && (kick_at < c);
    full     = &m_seen;
    if (polling) begin
      v = wdt_dat_i;
      push(c, 1'b0, 4'd2, 32'd0, 1'b0);
      if (v == 32'd0) begin
        m_late  = 1'b1;
        kick_at = c + 1;
      end else if (m_ctrl[2] && v > m_win) begin
        poll_at = c + PI + 1;
      end else begin
        kick_at = c + 1;
      end
    end
    if (kicking) begin
      push(c, 1'b1, 4'd4, 32'h5A5A_5A5A, 1'b1);
      m_kicks++;
      m_seen = hb;
    end else if (running) begin
      m_seen = m_seen | hb;
    end
    if (idle_run && m_ctrl[0] && full) poll_at = c + 1;
    if (rst || start) begin
      while (exp_q.size() > 0 && exp_q[$].cy > c) void'(exp_q.pop_back());
      poll_at = -1; kick_at = -1; m_seen = '0; m_late = 1'b0;
      if (rst) begin
        run_from = -1; m_win = '0; m_ctrl = '0;
      end else begin
        push(c + 1, 1'b1, 4'd4, 32'h1234_5678, 1'b0);
        push(c + 2, 1'b1, 4'd1, cfg_load_i, 1'b0);
        push(c + 3, 1'b1, 4'd3, cfg_window_i, 1'b0);
        push(c + 4, 1'b1, 4'd0, cfg_ctrl_i, 1'b0);
        push(c + 5, 1'b1, 4'd4, 32'hDEAD_BEEF, 1'b0);
        run_from = c + 6; m_win = cfg_window_i; m_ctrl = cfg_ctrl_i;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [31:0] ld, input logic [31:0] win, input logic [31:0] ctl);
    cfg_load_i = ld; cfg_window_i = win; cfg_ctrl_i = ctl;
    step('0, 1'b1, 1'b0);
  endtask

  task automatic rand_hb(input int n, input logic [NHB-1:0] mask);
    for (int i = 0; i < n; i++)
      step(($urandom_range(0, 2) == 0) ? (NHB'($urandom) & mask) : '0, 1'b0, 1'b0);
  endtask

  int base_rst, base_kick;

  initial begin
    @(posedge clk);
    #1;
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    idle(3);
    chk("reset_running", 32'(running_o), 32'd0);

    // Config without window mode, heartbeats on separate cycles -> one poll, one kick.
    cfg(32'h100, 32'h40, 32'h03);
    idle(6);
    base_kick = kick_obs;
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    idle(10);
    chk("single_kick", 32'(kick_obs - base_kick), 32'd1);
    chk("seen_cleared", 32'(hb_seen_o), 32'd0);

    // Heartbeat coincident with the kick carries into the next epoch.
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step((cyc == kick_at) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
    chk("hb_in_kick", 32'(hb_seen_o), 32'b0100);
    step(4'b1011, 1'b0, 1'b0);
    idle(6);

    // Window mode: polls repeat while COUNT is above the window; no expiry.
    cfg(32'h100, 32'h40, 32'h07);
    base_rst  = wd_rst_cnt;
    base_kick = kick_obs;
    rand_hb(600, 4'hF);
    chk("window_no_expiry", 32'(wd_rst_cnt - base_rst), 32'd0);
    chk("window_kicked", 32'(kick_obs > base_kick), 32'd1);

    // COUNT reads back 0 -> late flag.
    ovr_en = 1'b1; ovr_val = 32'd0;
    step(4'hF, 1'b0, 1'b0);
    idle(PI + 6);
    ovr_en = 1'b0;
    chk("late_set", 32'(late_o), 32'd1);

    // Restart in WR_WIN with new values; start also clears late.
    cfg(32'h80, 32'h20, 32'h05);
    idle(2);
    cfg(32'h200, 32'h30, 32'h07);
    chk("late_cleared", 32'(late_o), 32'd0);
    idle(6);
    rand_hb(300, 4'hF);

    // Only three sources alive: no kicks, the watchdog expires.
    cfg(32'h60, 32'h40, 32'h03);
    base_rst  = wd_rst_cnt;
    base_kick = kick_obs;
    rand_hb(300, 4'b0111);
    chk("stalled_no_kick", 32'(kick_obs - base_kick), 32'd0);
    chk("stalled_expired", 32'(wd_rst_cnt > base_rst), 32'd1);

    // Watchdog disabled: never polled or kicked.
    cfg(32'h100, 32'h40, 32'h06);
    base_kick = kick_obs;
    rand_hb(60, 4'hF);
    chk("disabled_no_kick", 32'(kick_obs - base_kick), 32'd0);

    // Random configurations.
    for (int k = 0; k < 3; k++) begin
      cfg(32'($urandom_range(64, 512)), 32'($urandom_range(8, 64)),
          32'($urandom_range(0, 7)));
      rand_hb(200, 4'hF);
    end

    // Synchronous reset mid-RUN.
    cfg(32'h100, 32'h40, 32'h03);
    idle(8);
    step('0, 1'b0, 1'b1);
    chk("rst_running", 32'(running_o), 32'd0);
    chk("rst_stb", 32'(wdt_stb_o), 32'd0);
    step('0, 1'b0, 1'b0);
    idle(3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("kick_total", 32'(kick_obs), 32'(m_kicks));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
